dmi_uart_host: RTL and testbench

- Host-side initiator for the UART debug framing protocol. Converts a parallel request (cmd, address, byte count, data) into the byte stream `HEADER`, `{cmd,addr}`, `length`, then data bytes on the UART TX FIFO.
- For reads, collects the target's response bytes from the RX FIFO and returns them as one parallel word.
- Used as an on-chip test master and as a synthesizable bench driver facing the DMI UART TAP across a UART link.
- Protocol constants (`HEADER`, `IRLENGTH`, `CMDLENGTH`, `CMD_*`, `ADDR_*`) come from `uart_pkg`.

---
 rtl/dmi_uart_host.sv | 224 ++++++++++++++++++++++
 tb/tb_dmi_uart_host.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_uart_host.sv
// uart_pkg: framing constants shared with the DMI UART TAP.
// dmi_uart_host: turns a parallel debug request into a UART frame and collects read responses.
package uart_pkg;
    localparam int unsigned IRLENGTH  = 5;
    localparam int unsigned CMDLENGTH = 3;

    localparam logic [7:0] HEADER = 8'hA5;

    localparam logic [CMDLENGTH-1:0] CMD_NOP   = 3'd0;
    localparam logic [CMDLENGTH-1:0] CMD_RESET = 3'd1;
    localparam logic [CMDLENGTH-1:0] CMD_READ  = 3'd2;
    localparam logic [CMDLENGTH-1:0] CMD_WRITE = 3'd3;

    localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;
    localparam logic [IRLENGTH-1:0] ADDR_DTMCS  = 5'h10;
    localparam logic [IRLENGTH-1:0] ADDR_DMI    = 5'h11;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_req_t;
endpackage

module dmi_uart_host
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE  = 100000000,
    parameter int unsigned BAUD_RATE = 3000000,
    parameter int unsigned MAX_BYTES = ($bits(dmi_req_t) + 7) / 8
) (
    input  logic                   CLK_I,
    input  logic                   RST_NI,
    input  logic                   REQ_VALID_I,
    output logic                   REQ_READY_O,
    input  logic [CMDLENGTH-1:0]   REQ_CMD_I,
    input  logic [IRLENGTH-1:0]    REQ_ADDR_I,
    input  logic [7:0]             REQ_NBYTES_I,
    input  logic [8*MAX_BYTES-1:0] REQ_DATA_I,
    output logic                   RSP_VALID_O,
    output logic [8*MAX_BYTES-1:0] RSP_DATA_O,
    output logic                   RSP_TIMEOUT_O,
    output logic                   WE_O,
    input  logic                   TX_READY_I,
    output logic [7:0]             DSEND_O,
    output logic                   RE_O,
    input  logic                   RX_EMPTY_I,
    input  logic [7:0]             DREC_I
);

    localparam int unsigned DW  = 8 * MAX_BYTES;
    localparam int unsigned TMO = 5 * ((10 * CLK_RATE) / BAUD_RATE);
    localparam int unsigned TW  = $clog2(TMO + 1);
    localparam int unsigned IW  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_CMDADDR,
        S_LENGTH,
        S_TXDATA,
        S_RXDATA,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CMDLENGTH-1:0] cmd_q;
    logic [IRLENGTH-1:0]  addr_q;
    logic [7:0]           nbytes_q;
    logic [DW-1:0]        data_q;
    logic [IW-1:0]        idx_q;
    logic [TW-1:0]        tmo_q;
    logic [DW-1:0]        rsp_data_q;
    logic                 rsp_timeout_q;
    logic                 rsp_valid_q;
    logic                 ready_q;

    logic                 accept_c;
    logic                 last_c;
    logic                 rx_byte_c;
    logic                 tmo_fire_c;
    logic [7:0]           nbytes_c;

    assign accept_c   = REQ_VALID_I & ready_q;
    assign nbytes_c   = (REQ_NBYTES_I > 8'(MAX_BYTES)) ? 8'(MAX_BYTES) : REQ_NBYTES_I;
    assign last_c     = (8'(idx_q) == (nbytes_q - 8'd1));
    assign rx_byte_c  = (state_q == S_RXDATA) & ~RX_EMPTY_I;
    // A byte present in the same cycle always wins over the timeout.
    assign tmo_fire_c = (state_q == S_RXDATA) & RX_EMPTY_I & (tmo_q == TW'(TMO - 1));

    assign REQ_READY_O   = ready_q;
    assign RSP_VALID_O   = rsp_valid_q;
    assign RSP_DATA_O    = rsp_data_q;
    assign RSP_TIMEOUT_O = rsp_timeout_q;

    // State register
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; send states advance only when a byte is actually written
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) state_d = S_HEADER;
            end
            S_HEADER: begin
                if (TX_READY_I) state_d = S_CMDADDR;
            end
            S_CMDADDR: begin
                if (TX_READY_I) state_d = S_LENGTH;
            end
            S_LENGTH: begin
                if (TX_READY_I) begin
                    if (nbytes_q == 8'd0)          state_d = S_DONE;
                    else if (cmd_q == CMD_WRITE)   state_d = S_TXDATA;
                    else if (cmd_q == CMD_READ)    state_d = S_RXDATA;
                    else                           state_d = S_DONE;
                end
            end
            S_TXDATA: begin
                if (TX_READY_I && last_c) state_d = S_DONE;
            end
            S_RXDATA: begin
                if (rx_byte_c && last_c) state_d = S_DONE;
                else if (tmo_fire_c)     state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO-side strobes and the byte for the current send state
    always_comb begin
        WE_O    = 1'b0;
        DSEND_O = 8'h00;
        RE_O    = 1'b0;
        case (state_q)
            S_IDLE: begin
                RE_O = ~RX_EMPTY_I;
            end
            S_HEADER: begin
                WE_O    = TX_READY_I;
                DSEND_O = HEADER;
            end
            S_CMDADDR: begin
                WE_O    = TX_READY_I;
                DSEND_O = 8'({cmd_q, addr_q});
            end
            S_LENGTH: begin
                WE_O    = TX_READY_I;
                DSEND_O = nbytes_q;
            end
            S_TXDATA: begin
                WE_O    = TX_READY_I;
                DSEND_O = data_q[8*idx_q +: 8];
            end
            S_RXDATA: begin
                RE_O = ~RX_EMPTY_I;
            end
            default: begin
                WE_O = 1'b0;
            end
        endcase
    end

    // Request latch, byte index, timeout counter and response registers
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            cmd_q         <= '0;
            addr_q        <= '0;
            nbytes_q      <= '0;
            data_q        <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            if (accept_c) begin
                cmd_q         <= REQ_CMD_I;
                addr_q        <= REQ_ADDR_I;
                data_q        <= REQ_DATA_I;
                nbytes_q      <= nbytes_c;
                rsp_data_q    <= '0;
                rsp_timeout_q <= 1'b0;
            end

            if (rx_byte_c) begin
                rsp_data_q[8*idx_q +: 8] <= DREC_I;
            end

            if (((state_q == S_TXDATA) && TX_READY_I) || rx_byte_c) begin
                idx_q <= idx_q + IW'(1);
            end else if (state_q == S_IDLE) begin
                idx_q <= '0;
            end

            if ((state_q == S_RXDATA) && RX_EMPTY_I) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end

            if (tmo_fire_c) begin
                rsp_timeout_q <= 1'b1;
            end

            rsp_valid_q <= (state_d == S_DONE);
            ready_q     <= (state_d == S_IDLE);
        end
    end

endmodule

// File: tb/tb_dmi_uart_host.sv
// Directed bench for dmi_uart_host: TX framing, reads, backpressure, timeout, edge counts, reset and drain.
module tb_dmi_uart_host;
    import uart_pkg::*;

    localparam int TMO = 50;

    logic        clk;
    logic        RST_NI;
    logic        REQ_VALID_I;
    logic        REQ_READY_O;
    logic [2:0]  REQ_CMD_I;
    logic [4:0]  REQ_ADDR_I;
    logic [7:0]  REQ_NBYTES_I;
    logic [47:0] REQ_DATA_I;
    logic        RSP_VALID_O;
    logic [47:0] RSP_DATA_O;
    logic        RSP_TIMEOUT_O;
    logic        WE_O;
    logic        TX_READY_I;
    logic [7:0]  DSEND_O;
    logic        RE_O;
    logic        RX_EMPTY_I;
    logic [7:0]  DREC_I;

    dmi_uart_host #(
        .CLK_RATE (1000000),
        .BAUD_RATE(1000000),
        .MAX_BYTES(6)
    ) dut (
        .CLK_I        (clk),
        .RST_NI       (RST_NI),
        .REQ_VALID_I  (REQ_VALID_I),
        .REQ_READY_O  (REQ_READY_O),
        .REQ_CMD_I    (REQ_CMD_I),
        .REQ_ADDR_I   (REQ_ADDR_I),
        .REQ_NBYTES_I (REQ_NBYTES_I),
        .REQ_DATA_I   (REQ_DATA_I),
        .RSP_VALID_O  (RSP_VALID_O),
        .RSP_DATA_O   (RSP_DATA_O),
        .RSP_TIMEOUT_O(RSP_TIMEOUT_O),
        .WE_O         (WE_O),
        .TX_READY_I   (TX_READY_I),
        .DSEND_O      (DSEND_O),
        .RE_O         (RE_O),
        .RX_EMPTY_I   (RX_EMPTY_I),
        .DREC_I       (DREC_I)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         acc_cyc, we_last_cyc, re_last_cyc, vld_cyc;
    int         vld_cnt = 0, vld_base = 0;
    int         re_cnt = 0, re_base = 0;
    int         we_bad = 0;
    logic       tmo_at_vld;
    logic       tx_toggle = 1'b0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] exp_wr[9];
    logic [47:0] d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tx_at(input int i);
        return (i < txq.size()) ? txq[i] : 8'hxx;
    endfunction

    task automatic rx_refresh();
        RX_EMPTY_I = (rxq.size() == 0);
        DREC_I     = RX_EMPTY_I ? 8'h00 : rxq[0];
    endtask

    task automatic rx_push(input logic [7:0] b);
        rxq.push_back(b);
        rx_refresh();
    endtask

    // One clock: observe mid-cycle, then update the FIFO model just after the edge
    task automatic tick();
        logic re_now;
        @(negedge clk);
        if (WE_O) begin
            txq.push_back(DSEND_O);
            we_last_cyc = cyc;
            if (!TX_READY_I) we_bad++;
        end
        re_now = RE_O;
        if (RE_O) begin
            re_cnt++;
            re_last_cyc = cyc;
        end
        if (RSP_VALID_O) begin
            vld_cnt++;
            vld_cyc    = cyc;
            tmo_at_vld = RSP_TIMEOUT_O;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (re_now && rxq.size() > 0) rxq.delete(0);
        if (tx_toggle) TX_READY_I = ~TX_READY_I;
        rx_refresh();
    endtask

    task automatic send_req(input logic [2:0] cmd, input logic [4:0] addr,
                            input logic [7:0] nb, input logic [47:0] data);
        chk("req_ready_idle", 64'(REQ_READY_O), 64'd1);
        REQ_VALID_I  = 1'b1;
        REQ_CMD_I    = cmd;
        REQ_ADDR_I   = addr;
        REQ_NBYTES_I = nb;
        REQ_DATA_I   = data;
        acc_cyc      = cyc;
        vld_base     = vld_cnt;
        re_base      = re_cnt;
        txq.delete();
        tick();
        REQ_VALID_I = 1'b0;
        chk("req_ready_drop", 64'(REQ_READY_O), 64'd0);
        chk("rsp_data_clr", 64'(RSP_DATA_O), 64'd0);
        chk("rsp_tmo_clr", 64'(RSP_TIMEOUT_O), 64'd0);
    endtask

    task automatic wait_rsp(input int budget, input string tag);
        int n;
        n = 0;
        while (vld_cnt == vld_base && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_seen"}, 64'(vld_cnt != vld_base), 64'd1);
        chk({tag, "_ready_back"}, 64'(REQ_READY_O), 64'd1);
    endtask

    initial begin
        RST_NI       = 1'b1;
        REQ_VALID_I  = 1'b0;
        REQ_CMD_I    = '0;
        REQ_ADDR_I   = '0;
        REQ_NBYTES_I = '0;
        REQ_DATA_I   = '0;
        TX_READY_I   = 1'b1;
        RX_EMPTY_I   = 1'b1;
        DREC_I       = 8'h00;
        #3 RST_NI = 1'b0;
        #4;
        chk("rst_ready", 64'(REQ_READY_O), 64'd1);
        chk("rst_valid", 64'(RSP_VALID_O), 64'd0);
        chk("rst_tmo", 64'(RSP_TIMEOUT_O), 64'd0);
        chk("rst_data", 64'(RSP_DATA_O), 64'd0);
        chk("rst_we", 64'(WE_O), 64'd0);
        chk("rst_re", 64'(RE_O), 64'd0);
        chk("rst_dsend", 64'(DSEND_O), 64'd0);
        @(posedge clk);
        #1 RST_NI = 1'b1;
        tick();
        tick();

        // Write, six bytes, no backpressure
        exp_wr = '{8'hA5, 8'h71, 8'h06, 8'h9B, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0A};
        send_req(CMD_WRITE, ADDR_DMI, 8'd6, 48'h0A123456789B);
        wait_rsp(40, "wr");
        chk("wr_tmo", 64'(tmo_at_vld), 64'd0);
        chk("wr_nbytes", 64'(txq.size()), 64'd9);
        for (int i = 0; i < 9; i++) chk($sformatf("wr_byte%0d", i), 64'(tx_at(i)), 64'(exp_wr[i]));
        chk("wr_last_we_lat", 64'(we_last_cyc - acc_cyc), 64'd9);
        chk("wr_vld_lat", 64'(vld_cyc - acc_cyc), 64'd10);
        tick();
        tick();
        chk("wr_one_pulse", 64'(vld_cnt - vld_base), 64'd1);

        // Stale RX bytes in IDLE are drained
        re_base = re_cnt;
        rx_push(8'hEE);
        rx_push(8'hDD);
        tick();
        tick();
        tick();
        chk("drain_re_cnt", 64'(re_cnt - re_base), 64'd2);
        chk("drain_empty", 64'(rxq.size()), 64'd0);

        // Read of four bytes with random gaps
        send_req(CMD_READ, ADDR_IDCODE, 8'd4, 48'h0);
        d = 48'h10_00_00_01;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            rx_push(d[8*i +: 8]);
        end
        wait_rsp(100, "rd");
        chk("rd_data", 64'(RSP_DATA_O), 64'h0000_1000_0001);
        chk("rd_tmo", 64'(tmo_at_vld), 64'd0);
        chk("rd_tx_n", 64'(txq.size()), 64'd3);
        chk("rd_tx_cmdaddr", 64'(tx_at(1)), 64'h41);
        chk("rd_tx_len", 64'(tx_at(2)), 64'h04);

        // Backpressure: TX_READY_I toggles every cycle
        d = 48'h665544332211;
        tx_toggle = 1'b1;
        send_req(CMD_WRITE, ADDR_DMI, 8'd6, d);
        wait_rsp(80, "bp");
        tx_toggle  = 1'b0;
        TX_READY_I = 1'b1;
        chk("bp_nbytes", 64'(txq.size()), 64'd9);
        chk("bp_hdr", 64'(tx_at(0)), 64'hA5);
        chk("bp_cmdaddr", 64'(tx_at(1)), 64'h71);
        chk("bp_len", 64'(tx_at(2)), 64'h06);
        for (int i = 0; i < 6; i++) chk($sformatf("bp_byte%0d", i), 64'(tx_at(3 + i)), 64'(d[8*i +: 8]));
        chk("bp_we_while_busy", 64'(we_bad), 64'd0);

        // Timeout: four bytes requested, only two delivered
        send_req(CMD_READ, ADDR_IDCODE, 8'd4, 48'h0);
        tick();
        tick();
        rx_push(8'hAA);
        tick();
        rx_push(8'hBB);
        wait_rsp(TMO + 20, "to");
        chk("to_flag", 64'(tmo_at_vld), 64'd1);
        chk("to_lat", 64'(vld_cyc - re_last_cyc), 64'(TMO + 1));
        chk("to_data", 64'(RSP_DATA_O), 64'h0000_0000_BBAA);
        chk("to_flag_hold", 64'(RSP_TIMEOUT_O), 64'd1);

        // Byte count above MAX_BYTES is clamped
        d = 48'hFFEEDDCCBBAA;
        send_req(CMD_WRITE, ADDR_DMI, 8'd9, d);
        wait_rsp(40, "clamp");
        chk("clamp_nbytes", 64'(txq.size()), 64'd9);
        chk("clamp_len", 64'(tx_at(2)), 64'h06);
        chk("clamp_last", 64'(tx_at(8)), 64'hFF);

        // Reset command: header, cmd/addr, length only
        send_req(CMD_RESET, ADDR_DTMCS, 8'd5, 48'h0);
        wait_rsp(20, "rstcmd");
        chk("rstcmd_nbytes", 64'(txq.size()), 64'd3);
        chk("rstcmd_cmdaddr", 64'(tx_at(1)), 64'h30);
        chk("rstcmd_len", 64'(tx_at(2)), 64'h05);

        // Zero-length read never pops RX; the leftover byte is drained once idle
        send_req(CMD_READ, ADDR_IDCODE, 8'd0, 48'h0);
        rx_push(8'h77);
        wait_rsp(20, "rd0");
        chk("rd0_no_re", 64'(re_cnt - re_base), 64'd0);
        chk("rd0_len", 64'(tx_at(2)), 64'h00);
        chk("rd0_rx_left", 64'(rxq.size()), 64'd1);
        tick();
        tick();
        chk("rd0_drained", 64'(rxq.size()), 64'd0);

        // Reset in the middle of a frame, after the cmd/addr byte
        send_req(CMD_WRITE, ADDR_DMI, 8'd6, 48'h0A123456789B);
        tick();
        tick();
        #2 RST_NI = 1'b0;
        #1;
        chk("mid_rst_we", 64'(WE_O), 64'd0);
        chk("mid_rst_dsend", 64'(DSEND_O), 64'd0);
        chk("mid_rst_ready", 64'(REQ_READY_O), 64'd1);
        chk("mid_rst_valid", 64'(RSP_VALID_O), 64'd0);
        tick();
        tick();
        tick();
        @(posedge clk);
        #1 RST_NI = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_rst_nbytes", 64'(txq.size()), 64'd2);
        chk("mid_rst_no_rsp", 64'(vld_cnt - vld_base), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
